// File: rtl/cordic_pkg.sv
// cordic_pkg: shared atan table, gain constant and FSM states (GAIN exists only with CORDIC_GAIN_COMP_EN)
package cordic_pkg;
    localparam logic [31:0] ATAN_TBL [32] = '{
        32'h20000000, 32'h12e4051d, 32'h09fb385b, 32'h051111d4,
        32'h028b0d43, 32'h0145d7e1, 32'h00a2f61e, 32'h00517c55,
        32'h0028be53, 32'h00145f2e, 32'h000a2f98, 32'h000517cc,
        32'h00028be6, 32'h000145f3, 32'h0000a2f9, 32'h0000517c,
        32'h000028be, 32'h0000145f, 32'h00000a2f, 32'h00000517,
        32'h0000028b, 32'h00000145, 32'h000000a2, 32'h00000051,
        32'h00000028, 32'h00000014, 32'h0000000a, 32'h00000005,
        32'h00000002, 32'h00000001, 32'h00000001, 32'h00000000
    };
    localparam logic [31:0] GAIN_K30 = 32'd652032944;
    typedef enum logic [1:0] {
        IDLE,
        ITER,
`ifdef CORDIC_GAIN_COMP_EN
        GAIN,
`endif
        OUT
    } state_t;
endpackage

// File: rtl/cordic_gain_mul.sv
// cordic_gain_mul: scales x by the inverse CORDIC gain, built only with CORDIC_GAIN_COMP_EN
`ifdef CORDIC_GAIN_COMP_EN
module cordic_gain_mul
    import cordic_pkg::*;
#(
    parameter int WW = 16
) (
    input  logic signed [WW-1:0] x_i,
    output logic signed [WW-1:0] p_o
);
    localparam logic [31:0] K = (GAIN_K30 + (32'd1 << (31 - WW))) >> (32 - WW);
    logic signed [2*WW-1:0] prod;
    assign prod = (2*WW)'(x_i) * (2*WW)'($signed({1'b0, K[WW-2:0]}));
    assign p_o = WW'(prod >>> (WW - 2));
endmodule
`endif

// File: rtl/cordic_vector.sv
// cordic_vector: iterative vectoring CORDIC giving magnitude and atan2 phase; CORDIC_GAIN_COMP_EN adds gain correction
module cordic_vector
    import cordic_pkg::*;
#(
    parameter int IW    = 10,
    parameter int WW    = 16,
    parameter int PW    = 14,
    parameter int NITER = 12
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic signed [IW-1:0] i_xcord,
    input  logic signed [IW-1:0] i_ycord,
    input  logic                 i_aux,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [IW+1:0]        o_mag,
    output logic [PW-1:0]        o_phase,
    output logic                 o_aux
);
    state_t                state_q, state_d;
    logic signed [WW-1:0]  x_q, x_d, y_q, y_d;
    logic [PW-1:0]         ph_q, ph_d, oph_q, oph_d;
    logic [4:0]            cnt_q, cnt_d;
    logic                  aux_q, aux_d, zero_q, zero_d, oaux_q, oaux_d;
    logic [IW+1:0]         mag_q, mag_d;
    logic signed [WW-1:0]  xe, ye, xs, ys, xi, yi;
    logic [32:0]           at;
    logic [PW-1:0]         step, phi;
    logic                  neg, up;

    function automatic logic [IW+1:0] rnd(input logic signed [WW-1:0] v);
        return (IW+2)'((v + (WW'(1) << (WW - IW - 3))) >> (WW - IW - 2));
    endfunction

`ifdef CORDIC_GAIN_COMP_EN
    logic signed [WW-1:0] gx;
    cordic_gain_mul #(.WW(WW)) u_gain (.x_i(x_q), .p_o(gx));
`endif

    assign xe   = {{2{i_xcord[IW-1]}}, i_xcord, {(WW-IW-2){1'b0}}};
    assign ye   = {{2{i_ycord[IW-1]}}, i_ycord, {(WW-IW-2){1'b0}}};
    assign neg  = i_xcord[IW-1];
    assign xs   = x_q >>> cnt_q;
    assign ys   = y_q >>> cnt_q;
    // table holds atan in 2^32-per-circle units; keep the top PW bits, rounded
    assign at   = {1'b0, ATAN_TBL[cnt_q]} + (33'd1 << (31 - PW));
    assign step = PW'(at >> (32 - PW));
    assign up   = !y_q[WW-1];
    assign xi   = up ? x_q + ys : x_q - ys;
    assign yi   = up ? y_q - xs : y_q + xs;
    assign phi  = up ? ph_q + step : ph_q - step;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        ph_d    = ph_q;
        cnt_d   = cnt_q;
        aux_d   = aux_q;
        zero_d  = zero_q;
        mag_d   = mag_q;
        oph_d   = oph_q;
        oaux_d  = oaux_q;
        case (state_q)
            IDLE: if (i_valid) begin
                x_d     = neg ? -xe : xe;
                y_d     = neg ? -ye : ye;
                ph_d    = neg ? {1'b1, {(PW-1){1'b0}}} : '0;
                cnt_d   = '0;
                aux_d   = i_aux;
                zero_d  = (i_xcord == '0) && (i_ycord == '0);
                state_d = ITER;
            end
            ITER: begin
                x_d   = xi;
                y_d   = yi;
                ph_d  = phi;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(NITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = GAIN;
`else
                    state_d = OUT;
                    mag_d   = rnd(xi);
                    oph_d   = zero_q ? '0 : phi;
                    oaux_d  = aux_q;
`endif
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            GAIN: begin
                state_d = OUT;
                mag_d   = rnd(gx);
                oph_d   = zero_q ? '0 : ph_q;
                oaux_d  = aux_q;
            end
`endif
            OUT: state_d = i_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            ph_q    <= '0;
            cnt_q   <= '0;
            aux_q   <= 1'b0;
            zero_q  <= 1'b0;
            mag_q   <= '0;
            oph_q   <= '0;
            oaux_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            aux_q   <= aux_d;
            zero_q  <= zero_d;
            mag_q   <= mag_d;
            oph_q   <= oph_d;
            oaux_q  <= oaux_d;
        end
    end

    assign o_ready = state_q == IDLE;
    assign o_valid = state_q == OUT;
    assign o_mag   = mag_q;
    assign o_phase = oph_q;
    assign o_aux   = oaux_q;
endmodule

// File: doc/cordic_vector.md
CORDIC_VECTOR -- requirements
Module: cordic_vector

Interface
REQ-001 The block SHALL have these parameters:
- IW, 10, input coordinate width, signed.
- WW, 16, internal datapath width; WW >= IW+3.
- PW, 14, phase width; full circle is 2^PW.
- NITER, 12, iteration count; 1 <= NITER <= WW-2.

REQ-002 The block SHALL have these ports, one clock, reset synchronous active-high:
- i_clk, in, 1, clock.
- i_reset, in, 1, synchronous active-high reset.
- i_valid, in, 1, input request.
- o_ready, out, 1, block can accept an input.
- i_xcord, in, IW, signed x coordinate.
- i_ycord, in, IW, signed y coordinate.
- i_aux, in, 1, tag returned with the result.
- o_valid, out, 1, result available.
- i_ready, in, 1, consumer accepts the result.
- o_mag, out, IW+2, unsigned magnitude.
- o_phase, out, PW, unsigned atan2(y,x) mod 2^PW.
- o_aux, out, 1, tag that accompanied the input.

Function
REQ-003 The block SHALL be an iterative, vectoring-mode CORDIC whose FSM states are IDLE, ITER, GAIN (present only with the macro of REQ-015) and OUT.
REQ-004 o_ready SHALL be 1 only in IDLE; an input is accepted on a rising edge where i_valid && o_ready.
REQ-005 Input preparation on accept:
- Each coordinate is sign-extended by 2 guard bits and padded with WW-IW-2 zero fraction bits.
- If x < 0, both coordinates are negated and the phase accumulator is loaded with 2^(PW-1); otherwise it is loaded with 0.
- The iteration counter is cleared, i_aux is captured, and the FSM enters ITER.
REQ-006 Each ITER cycle k (0..NITER-1) SHALL update the state as follows:
- If y >= 0: x += y>>>k, y -= x>>>k, phase += ATAN[k].
- Otherwise: x -= y>>>k, y += x>>>k, phase -= ATAN[k].
- All shifts use the pre-update values.
REQ-007 ATAN[k] SHALL be round(atan(2^-k)·2^PW/(2π)); ATAN[0] = 2^(PW-3).
REQ-008 Phase arithmetic SHALL wrap modulo 2^PW with no saturation.
REQ-009 After iteration NITER-1, the FSM SHALL go to GAIN if the macro of REQ-015 is defined, otherwise to OUT.
REQ-010 On entry to OUT, the block SHALL register:
- o_mag = x rounded half-up at bit WW-IW-2, upper bits dropped.
- o_phase = the phase accumulator.
- o_aux = the captured tag.
REQ-011 Latency SHALL be exactly NITER+1 rising edges from the accept edge to o_valid=1, plus one edge if GAIN is present.
REQ-012 In OUT, o_valid=1 and all outputs SHALL hold stable until an edge with i_ready=1, after which the FSM goes to IDLE and o_valid=0.
- An input is accepted no earlier than the edge following that IDLE entry.
REQ-013 Boundary behaviour:
- Input x=y=0 SHALL produce o_mag=0 and o_phase=0; the phase is forced to zero.
- Input x=-2^(IW-1), y=0 SHALL produce o_phase=2^(PW-1) with no overflow.
- i_valid outside IDLE SHALL be ignored.

Reset
REQ-014 While i_reset=1 at a rising edge, the block SHALL enter IDLE and clear o_valid, o_mag, o_phase, o_aux, the datapath and the counter.
- Any in-flight operation is discarded.
- o_ready=1 on the cycle after reset is released.

Configuration
REQ-015 Macro CORDIC_GAIN_COMP_EN:
- Defined: state GAIN multiplies x by the constant round(0.607253·2^(WW-2)) and rescales to WW bits, so o_mag ≈ sqrt(x²+y²).
- Undefined: there is no GAIN state, no multiplier, and o_mag ≈ 1.64676·sqrt(x²+y²).

Structure
REQ-016 The shared package cordic_pkg SHALL hold:
- The 32-entry atan table (32-bit, circle=2^32), from which the top PW bits, rounded, are used.
- The gain constant.
- The FSM state enum.
REQ-017 The GAIN multiply SHALL be the sub-module cordic_gain_mul; the iteration step SHALL be inline.

Verification (IW=10, PW=14, NITER=12, CORDIC_GAIN_COMP_EN defined; tolerance ±2 LSB)
REQ-018 (256,0) -> o_phase 0, o_mag 256; with the macro undefined, o_mag 422.
REQ-019 (0,256) -> o_phase 4096, o_mag 256; (100,-100) -> o_phase 14336, o_mag 141.
REQ-020 (-512,0) -> o_phase 8192, o_mag 512; (0,0) -> o_mag 0, o_phase 0 exactly.
REQ-021 Accept, then check o_valid after exactly 14 edges (13 with the macro undefined).
- Hold i_ready=0 for 5 cycles: outputs stable, o_ready=0, i_valid pulses ignored.
- o_aux equals i_aux.
REQ-022 Assert i_reset during ITER -> o_valid=0 and o_ready=1 on the next cycle, and the next accepted input yields a correct result.
